// File: rtl/multi_way_dual_port_lutram_pkg.sv
// Shared definitions for the multi-way dual-port LUTRAM.
//   - lutram_state_t : clear-sweep sequencer states (INIT, READY)
//   - BYTE_WIDTH     : width of one byte-enable lane
//   - byte_merge()   : byte-masked merge of an old and a new entry, used by
//                      both the bank write path and the optional bypass.
//                      It works at a fixed maximum width; callers widen their
//                      operands with a size cast and narrow the result the
//                      same way, so any entry width up to MAX_ENTRY_BITS works.
package multi_way_dual_port_lutram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } lutram_state_t;

    localparam int BYTE_WIDTH     = 8;
    localparam int MAX_ENTRY_BITS = 1024;
    localparam int MAX_MASK_LEN   = MAX_ENTRY_BITS / BYTE_WIDTH;

    function automatic logic [MAX_ENTRY_BITS-1:0] byte_merge(
        input logic [MAX_ENTRY_BITS-1:0] old_entry,
        input logic [MAX_ENTRY_BITS-1:0] new_entry,
        input logic [MAX_MASK_LEN-1:0]   byte_mask
    );
        logic [MAX_ENTRY_BITS-1:0] merged;
        merged = old_entry;
        for (int i = 0; i < MAX_MASK_LEN; i++) begin
            if (byte_mask[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_entry[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/multi_way_dual_port_lutram_way_bank.sv
// One way of the LUTRAM: NUMBER_SET entries of ENTRY_BITS each.
// Byte-masked synchronous write, asynchronous (combinational) read.
// Ports:
//   clk         - write clock
//   we          - write strobe
//   write_addr  - write set index (dropped when >= NUMBER_SET)
//   byte_mask   - byte enables for the write
//   write_entry - write data
//   read_addr   - read set index (reads zero when >= NUMBER_SET)
//   read_entry  - combinational read data
module lutram_way_bank
    import multi_way_dual_port_lutram_pkg::*;
#(
    parameter int ENTRY_BITS = 64,
    parameter int NUMBER_SET = 64,
    parameter int SET_W      = 6,
    parameter int MASK_LEN   = ENTRY_BITS / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [SET_W-1:0]      write_addr,
    input  logic [MASK_LEN-1:0]   byte_mask,
    input  logic [ENTRY_BITS-1:0] write_entry,
    input  logic [SET_W-1:0]      read_addr,
    output logic [ENTRY_BITS-1:0] read_entry
);

    // No reset on the array itself: the top-level clear sweep zeroes it.
    logic [ENTRY_BITS-1:0] mem [NUMBER_SET];
    logic write_in_range;
    logic read_in_range;

    // Index space may exceed NUMBER_SET when the depth is not a power of two.
    assign write_in_range = (32'(write_addr) < NUMBER_SET);
    assign read_in_range  = (32'(read_addr)  < NUMBER_SET);

    always_ff @(posedge clk) begin
        if (we && write_in_range) begin
            mem[write_addr] <= ENTRY_BITS'(byte_merge(MAX_ENTRY_BITS'(mem[write_addr]),
                                                      MAX_ENTRY_BITS'(write_entry),
                                                      MAX_MASK_LEN'(byte_mask)));
        end
    end

    assign read_entry = read_in_range ? mem[read_addr] : '0;

endmodule

// File: rtl/multi_way_dual_port_lutram.sv
// Multi-way dual-port LUTRAM for cache tag/metadata arrays.
// NUMBER_WAY ways per set, independent read/write ports, byte-masked writes,
// registered read data with a valid strobe, and a post-reset clear sweep.
// Optional macro LUTRAM_WRITE_FIRST_BYPASS_EN: a same-cycle read and write to
// the same set returns the merged (post-write) data instead of the old data.
// Ports:
//   clk_in, reset_in (sync, active-high)
//   init_busy_out      - high while the clear sweep runs; requests ignored
//   read_en_in, read_set_addr_in, read_way_entry_out, read_valid_out
//   write_en_in, write_set_addr_in, write_way_mask_in, write_byte_mask_in,
//   write_entry_in     - data broadcast to every selected way
module multi_way_dual_port_lutram
    import multi_way_dual_port_lutram_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUMBER_SET                = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUMBER_SET),
    parameter int NUMBER_WAY                = 4,
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / 8
) (
    input  logic                                            clk_in,
    input  logic                                            reset_in,
    output logic                                            init_busy_out,
    input  logic                                            read_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                read_set_addr_in,
    output logic [NUMBER_WAY*SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_way_entry_out,
    output logic                                            read_valid_out,
    input  logic                                            write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                write_set_addr_in,
    input  logic [NUMBER_WAY-1:0]                           write_way_mask_in,
    input  logic [WRITE_MASK_LEN-1:0]                       write_byte_mask_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]            write_entry_in
);

    localparam int ENTRY_W = SINGLE_ENTRY_SIZE_IN_BITS;
    localparam int ROW_W   = NUMBER_WAY * ENTRY_W;

    lutram_state_t                    state, state_next;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] clear_cnt, clear_cnt_next;
    logic                             clear_last;
    logic                             ready;
    logic                             read_accept;

    // Bank write port: the sweep owns it during INIT, the user port afterwards.
    logic [NUMBER_WAY-1:0]            bank_we;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] bank_waddr;
    logic [WRITE_MASK_LEN-1:0]        bank_bmask;
    logic [ENTRY_W-1:0]               bank_wdata;
    logic [ROW_W-1:0]                 read_row;

    assign ready         = (state == READY);
    assign init_busy_out = ~ready;
    assign clear_last    = (32'(clear_cnt) == NUMBER_SET - 1);
    assign read_accept   = ready && read_en_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state     <= INIT;
            clear_cnt <= '0;
        end else begin
            state     <= state_next;
            clear_cnt <= clear_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        clear_cnt_next = clear_cnt;
        case (state)
            INIT: begin
                clear_cnt_next = clear_cnt + 1'b1;
                if (clear_last) begin
                    state_next     = READY;
                    clear_cnt_next = '0;
                end
            end
            READY:   ;
            default: state_next = INIT;
        endcase
    end

    assign bank_waddr = ready ? write_set_addr_in  : clear_cnt;
    assign bank_bmask = ready ? write_byte_mask_in : '1;
    assign bank_wdata = ready ? write_entry_in     : '0;

    genvar w;
    generate
        for (w = 0; w < NUMBER_WAY; w++) begin : g_way
            logic [ENTRY_W-1:0] bank_rdata;

            assign bank_we[w] = ready ? (write_en_in && write_way_mask_in[w]) : 1'b1;

            lutram_way_bank #(
                .ENTRY_BITS (ENTRY_W),
                .NUMBER_SET (NUMBER_SET),
                .SET_W      (SET_PTR_WIDTH_IN_BITS),
                .MASK_LEN   (WRITE_MASK_LEN)
            ) u_bank (
                .clk         (clk_in),
                .we          (bank_we[w]),
                .write_addr  (bank_waddr),
                .byte_mask   (bank_bmask),
                .write_entry (bank_wdata),
                .read_addr   (read_set_addr_in),
                .read_entry  (bank_rdata)
            );

`ifdef LUTRAM_WRITE_FIRST_BYPASS_EN
            // Forward the merged entry so the read sees what a next-cycle read
            // would; out-of-range sets read zero and drop writes, so no bypass.
            logic bypass_hit;
            assign bypass_hit = bank_we[w] && ready
                             && (write_set_addr_in == read_set_addr_in)
                             && (32'(read_set_addr_in) < NUMBER_SET);
            assign read_row[w*ENTRY_W +: ENTRY_W] = bypass_hit
                ? ENTRY_W'(byte_merge(MAX_ENTRY_BITS'(bank_rdata),
                                      MAX_ENTRY_BITS'(write_entry_in),
                                      MAX_MASK_LEN'(write_byte_mask_in)))
                : bank_rdata;
`else
            assign read_row[w*ENTRY_W +: ENTRY_W] = bank_rdata;
`endif
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            read_valid_out     <= 1'b0;
            read_way_entry_out <= '0;
        end else begin
            read_valid_out <= read_accept;
            if (read_accept) begin
                read_way_entry_out <= read_row;
            end
        end
    end

endmodule

// File: tb/tb_multi_way_dual_port_lutram.sv
// Self-checking bench for multi_way_dual_port_lutram (default parameters).
// A behavioural model of the array predicts each read; the predicted row is
// queued when the read is issued and popped when read_valid_out is expected.
// Honours LUTRAM_WRITE_FIRST_BYPASS_EN for same-cycle read/write expectations.
module tb_multi_way_dual_port_lutram;

    localparam int SIZE  = 64;
    localparam int SETS  = 64;
    localparam int AW    = 6;
    localparam int WAYS  = 4;
    localparam int ML    = SIZE / 8;
    localparam int ROW_W = WAYS * SIZE;

    logic              clk_in = 1'b0;
    logic              reset_in = 1'b1;
    logic              init_busy_out;
    logic              read_en_in = 1'b0;
    logic [AW-1:0]     read_set_addr_in = '0;
    logic [ROW_W-1:0]  read_way_entry_out;
    logic              read_valid_out;
    logic              write_en_in = 1'b0;
    logic [AW-1:0]     write_set_addr_in = '0;
    logic [WAYS-1:0]   write_way_mask_in = '0;
    logic [ML-1:0]     write_byte_mask_in = '0;
    logic [SIZE-1:0]   write_entry_in = '0;

    multi_way_dual_port_lutram dut (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .init_busy_out      (init_busy_out),
        .read_en_in         (read_en_in),
        .read_set_addr_in   (read_set_addr_in),
        .read_way_entry_out (read_way_entry_out),
        .read_valid_out     (read_valid_out),
        .write_en_in        (write_en_in),
        .write_set_addr_in  (write_set_addr_in),
        .write_way_mask_in  (write_way_mask_in),
        .write_byte_mask_in (write_byte_mask_in),
        .write_entry_in     (write_entry_in)
    );

    always #5 clk_in = ~clk_in;

    int n_assert = 0;
    int n_fail   = 0;

    logic [SIZE-1:0]  model [SETS][WAYS];
    logic [ROW_W-1:0] exp_q [$];
    logic [ROW_W-1:0] m_last = '0;
    bit               m_ready = 0;
    int               m_cnt = 0;

    task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [SIZE-1:0] merge(input logic [SIZE-1:0] o, input logic [SIZE-1:0] n,
                                              input logic [ML-1:0] m);
        logic [SIZE-1:0] r;
        r = o;
        for (int i = 0; i < ML; i++)
            if (m[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic model_write();
        if (write_en_in)
            for (int w = 0; w < WAYS; w++)
                if (write_way_mask_in[w])
                    model[write_set_addr_in][w] = merge(model[write_set_addr_in][w],
                                                        write_entry_in, write_byte_mask_in);
    endtask

    // One clock: predict with the currently driven inputs, then compare.
    task automatic cycle();
        logic [ROW_W-1:0] row;
        if (reset_in) begin
            m_ready = 0; m_cnt = 0; m_last = '0; exp_q.delete();
        end else if (!m_ready) begin
            for (int w = 0; w < WAYS; w++) model[m_cnt][w] = '0;
            if (m_cnt == SETS - 1) begin m_ready = 1; m_cnt = 0; end
            else m_cnt++;
        end else begin
`ifdef LUTRAM_WRITE_FIRST_BYPASS_EN
            model_write();
`endif
            if (read_en_in) begin
                for (int w = 0; w < WAYS; w++) row[w*SIZE +: SIZE] = model[read_set_addr_in][w];
                exp_q.push_back(row);
            end
`ifndef LUTRAM_WRITE_FIRST_BYPASS_EN
            model_write();
`endif
        end
        @(posedge clk_in); #1;
        check("busy", ROW_W'(init_busy_out), ROW_W'(!m_ready));
        if (exp_q.size() > 0) begin
            check("valid_hi", ROW_W'(read_valid_out), ROW_W'(1));
            m_last = exp_q.pop_front();
        end else begin
            check("valid_lo", ROW_W'(read_valid_out), ROW_W'(0));
        end
        check("rdata", read_way_entry_out, m_last);
    endtask

    task automatic do_write(input int s, input logic [WAYS-1:0] wm, input logic [ML-1:0] bm,
                            input logic [SIZE-1:0] d);
        write_en_in = 1; write_set_addr_in = AW'(s); write_way_mask_in = wm;
        write_byte_mask_in = bm; write_entry_in = d;
        cycle();
        write_en_in = 0;
    endtask

    task automatic do_read(input int s);
        read_en_in = 1; read_set_addr_in = AW'(s);
        cycle();
        read_en_in = 0;
    endtask

    task automatic sweep(input bit noisy, output int n);
        n = 0;
        while (init_busy_out && n < 200) begin
            if (noisy) begin
                read_en_in = 1; write_en_in = 1;
                read_set_addr_in = AW'($urandom); write_set_addr_in = AW'($urandom);
                write_way_mask_in = '1; write_byte_mask_in = '1;
                write_entry_in = {$urandom, $urandom};
            end
            cycle();
            n++;
        end
        read_en_in = 0; write_en_in = 0;
    endtask

    initial begin
        int n;
        logic [SIZE-1:0] bp_exp;
        // Reset state
        reset_in = 1;
        cycle(); cycle();
        reset_in = 0;
        sweep(0, n);
        check("init_cycles", ROW_W'(n), ROW_W'(64));

        // Freshly cleared set 63
        do_read(63);
        check("set63_zero", read_way_entry_out, '0);
        cycle();

        // Way mask 0101
        do_write(63, 4'b0101, 8'hFF, 64'hFFFFFFFF_00000000);
        do_read(63);
        check("wm0101", read_way_entry_out,
              {64'h0, 64'hFFFFFFFF_00000000, 64'h0, 64'hFFFFFFFF_00000000});

        // Byte mask 0F
        do_write(5, 4'b0001, 8'hFF, 64'hAAAAAAAA_AAAAAAAA);
        do_write(5, 4'b0001, 8'h0F, 64'h00000000_FFFFFFFF);
        do_read(5);
        check("bm0F", read_way_entry_out[63:0], 64'hAAAAAAAA_FFFFFFFF);

        // Zero masks are no-ops
        do_write(5, 4'b0000, 8'hFF, 64'h1111_2222_3333_4444);
        do_write(5, 4'b1111, 8'h00, 64'h5555_6666_7777_8888);

        // write_en_in low with live data/address: nothing changes, no valid
        write_set_addr_in = 6'd5; write_way_mask_in = '1; write_byte_mask_in = '1;
        write_entry_in = 64'hDEADBEEF_CAFEF00D;
        repeat (3) cycle();
        do_read(5);
        check("hold5", read_way_entry_out[63:0], 64'hAAAAAAAA_FFFFFFFF);
        do_read(63);
        cycle();
        check("held_out", read_way_entry_out[191:128], 64'hFFFFFFFF_00000000);

        // Same-cycle read and write to set 10
        read_en_in = 1; read_set_addr_in = 6'd10;
        do_write(10, 4'b0010, 8'hFF, 64'h1234);
        read_en_in = 0;
`ifdef LUTRAM_WRITE_FIRST_BYPASS_EN
        bp_exp = 64'h1234;
`else
        bp_exp = 64'h0;
`endif
        check("rw_same", read_way_entry_out[127:64], bp_exp);
        do_read(10);
        check("rw_next", read_way_entry_out[127:64], 64'h1234);

        // A few mixed random transactions
        for (int k = 0; k < 20; k++) begin
            read_en_in = 1'($urandom); read_set_addr_in = AW'($urandom_range(0, 15));
            do_write($urandom_range(0, 15), WAYS'($urandom), ML'($urandom), {$urandom, $urandom});
        end
        read_en_in = 0;
        cycle();

        // Reset after writes, again 20 cycles into the sweep, requests while busy
        reset_in = 1; cycle(); reset_in = 0;
        for (int k = 0; k < 20; k++) begin
            read_en_in = 1; write_en_in = 1; write_way_mask_in = '1; write_byte_mask_in = '1;
            read_set_addr_in = AW'(k); write_set_addr_in = AW'(k); write_entry_in = 64'hFFFF;
            cycle();
        end
        reset_in = 1; cycle(); reset_in = 0;
        sweep(1, n);
        check("reinit_cycles", ROW_W'(n), ROW_W'(64));
        for (int s = 0; s < SETS; s++) begin
            do_read(s);
            check("cleared", read_way_entry_out, '0);
        end
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_way_dual_port_lutram.md
Name: multi_way_dual_port_lutram

Overview:
- Next-generation LUTRAM storage for cache tag/metadata arrays.
- Generalises the single-port, single-entry LUTRAM to NUMBER_WAY ways per set, with independent read and write ports and byte-granular write masking.
- Adds a self-clearing init sequencer that zeroes every entry after reset.
- Read data is registered, with a valid strobe.

Parameters:
- SINGLE_ENTRY_SIZE_IN_BITS, 64, width of one way entry; must be a multiple of 8.
- NUMBER_SET, 64, number of sets; need not be a power of two.
- SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SET), set address width.
- NUMBER_WAY, 4, ways per set.
- WRITE_MASK_LEN, SINGLE_ENTRY_SIZE_IN_BITS/8, byte-enable count per entry.

Ports:
- clk_in  input  1  single clock
- reset_in  input  1  synchronous, active-high reset
- init_busy_out  output  1  high while the clear sweep runs
- read_en_in  input  1  read request
- read_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  read set index
- read_way_entry_out  output  NUMBER_WAY*SINGLE_ENTRY_SIZE_IN_BITS  all ways of the set; way w occupies bits [w*SIZE +: SIZE]
- read_valid_out  output  1  read_way_entry_out valid this cycle
- write_en_in  input  1  write request
- write_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  write set index
- write_way_mask_in  input  NUMBER_WAY  ways to write
- write_byte_mask_in  input  WRITE_MASK_LEN  byte enables; bit i covers bits [8i+7:8i]
- write_entry_in  input  SINGLE_ENTRY_SIZE_IN_BITS  data, broadcast to every selected way

Behaviour:
- Clock and reset: one clock, clk_in; reset_in is synchronous and active-high. All state updates on the rising edge.
- Reset values: init_busy_out=1, read_valid_out=0, read_way_entry_out=0, state=INIT, clear counter=0.
- FSM has two states, INIT and READY.
- INIT:
  - Each cycle writes zero to all ways of set[counter], then counter increments.
  - The last clear write goes to set NUMBER_SET-1; on that edge, state becomes READY and init_busy_out drops.
  - init_busy_out is therefore high for exactly NUMBER_SET cycles after reset_in deasserts.
- Requests during INIT: read_en_in and write_en_in are ignored. read_valid_out stays 0. Storage receives only the clear writes.
- Reset mid-operation: reset_in asserted in any state (including mid-INIT) restarts at INIT with counter=0. Any in-flight read is dropped and read_valid_out=0.
- Write (READY, write_en_in=1):
  - Applied at the clock edge.
  - For each way w with write_way_mask_in[w]=1, byte i of the entry is updated only where write_byte_mask_in[i]=1.
  - An all-zero way mask or all-zero byte mask is a no-op.
- Read (READY, read_en_in=1):
  - Latency 1 cycle: data and read_valid_out appear on the next edge.
  - read_valid_out is a one-cycle pulse per accepted read.
  - read_way_entry_out holds its last value when no read is accepted.
- Read after write: a write at edge N is visible to a read requested in cycle N+1.
- Same-cycle read and write to the same set: returns pre-write data (read-old), unless the optional feature below is compiled in.
- Out-of-range address (set >= NUMBER_SET, non-power-of-two depth): writes dropped; reads return all-zero with read_valid_out=1.
- Storage: asynchronous-read LUT array; only the output register is clocked.

Optional Feature:
- Macro: LUTRAM_WRITE_FIRST_BYPASS_EN.
- Defined: a same-cycle read and write to the same set returns the merged data, i.e. the byte-masked new data in selected ways and the old data elsewhere. This is exactly what a read issued the next cycle would see.
- Undefined: read-old behaviour as above; no bypass mux is synthesised.

Decomposition:
- Shared package:
  - FSM state encoding (INIT, READY).
  - BYTE_WIDTH=8 constant.
  - Function computing the byte-masked merge of old and new entry; the write path and the bypass use the same function.
- Sub-module lutram_way_bank:
  - One way: NUMBER_SET x SINGLE_ENTRY_SIZE_IN_BITS.
  - Byte-masked synchronous write, asynchronous read.
  - Instantiated NUMBER_WAY times via generate.

Test Plan:
- Reset released -> init_busy_out high exactly 64 cycles. Then read set 63 -> read_valid_out=1 one cycle later, all four ways = 64'h0.
- Write set 63, way mask 4'b0101, byte mask 8'hFF, data 64'hFFFFFFFF_00000000; read set 63 next cycle -> ways 0,2 = data, ways 1,3 = 0.
- Way 0, set 5 holds 64'hAAAAAAAA_AAAAAAAA; write 64'h00000000_FFFFFFFF with byte mask 8'h0F -> readback 64'hAAAAAAAA_FFFFFFFF.
- write_en_in=0 with new data/address for 3 cycles -> contents unchanged; no read_valid_out without read_en_in.
- Same-cycle read+write set 10, way 1, data 64'h1234: undefined macro -> old value (0); defined macro -> 64'h1234. Both builds: next-cycle read -> 64'h1234.
- Reset asserted at cycle 20 of init, and again after writes; requests issued while busy are ignored -> read_valid_out=0 while busy, and every entry is zero after a fresh 64-cycle sweep.
